// File: rtl/lsl_pkg.sv
// Shared definitions for the LSL serializer.
//   state_t    : serializer FSM states (IDLE, SHIFT)
//   DEFAULT_N  : default MSB index of the parallel word (word width N+1)
//   cnt_width  : width of a counter that must hold 0..n without wrapping
package lsl_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int DEFAULT_N = 7;

  // ceil(log2(n+1)), kept at least 1 so a one-bit word still gets a legal vector.
  function automatic int cnt_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

endpackage

// File: rtl/lsl_serializer_bit_counter.sv
// Bit counter for the LSL serializer.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset, count -> 0
//   clr   : synchronous clear, count -> 0 (below rst in priority)
//   en    : increment enable (below clr in priority)
//   count : current count, WIDTH bits
module bit_counter #(
  parameter int WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lsl_serializer.sv
// Parallel-to-serial converter, MSB first, with valid/ready on both sides.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_data   : parallel word (N+1 bits)
//   in_valid  : in_data valid
//   in_ready  : serializer idle, can accept a word
//   ser_out   : current serial bit (shreg MSB while shifting, else 0)
//   ser_valid : ser_out valid
//   ser_ready : downstream consumes ser_out
//   ser_last  : ser_out is the LSB of the word
//   shreg     : live shift-register contents
//   busy      : word in flight; also the FSM state (1 = SHIFT, 0 = IDLE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready depends only on state, never on in_valid; ser_valid
// depends only on state, never on ser_ready. While a word is in flight the
// input side is closed, so in_valid/in_data are ignored during SHIFT.
module lsl_serializer
  import lsl_pkg::*;
#(
  parameter int N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N:0]   in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic         ser_out,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         ser_last,
  output logic [N:0]   shreg,
  output logic         busy
);

  localparam int CW = cnt_width(N);

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic          load;
  logic          xfer;
  logic          last;

  assign last = (state == SHIFT) && (cnt == CW'(N));
  assign xfer = ser_valid && ser_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    ser_valid = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load    = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        ser_valid = 1'b1;
        busy      = 1'b1;
        if (ser_ready && last) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Zero-filling left shift: after the LSB leaves, shreg is all zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
    end else if (load) begin
      shreg <= in_data;
    end else if (xfer) begin
      shreg <= shreg << 1;
    end
  end

  // The counter stops at N: the last transfer clears it instead of
  // incrementing, so it never wraps and IDLE always sees cnt == 0.
  bit_counter #(
    .WIDTH(CW)
  ) u_bit_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (load || (xfer && last)),
    .en   (xfer && !last),
    .count(cnt)
  );

  assign ser_last = last;
  assign ser_out  = (state == SHIFT) ? shreg[N] : 1'b0;

endmodule

// File: tb/tb_lsl_serializer.sv
module tb_lsl_serializer;

  localparam int N = 7;
  localparam int W = N + 1;

  logic         clk;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_ready;
  logic         ser_last;
  logic [W-1:0] shreg;
  logic         busy;

  int errors = 0;
  int checks = 0;

  // Expected serial bits of the word in flight, MSB first.
  logic exp_q[$];

  lsl_serializer #(.N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .ser_ready(ser_ready),
    .ser_last (ser_last),
    .shreg    (shreg),
    .busy     (busy)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  // Driver and scoreboard for one word. Called at a negedge while the DUT is
  // idle; returns at the negedge after the word completes (or is aborted).
  //   stall_at/stall_len : hold ser_ready low for stall_len cycles once
  //                        stall_at bits have been transferred
  //   rand_ready         : random ser_ready instead of the stall pattern
  //   junk               : hold in_valid high with other data during SHIFT
  //   abort_at           : pulse rst once abort_at bits have been transferred
  task automatic send_word(input logic [W-1:0] data, input int stall_at,
                           input int stall_len, input bit rand_ready,
                           input bit junk, input int abort_at);
    logic [W-1:0] model_sr;
    int sent;
    int stalled;
    int cycles;
    bit rdy;
    in_data  = data;
    in_valid = 1'b1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL accept_ready: got %b expected 1", in_ready); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL accept_busy: got %b expected 0", busy); end
    @(posedge clk);
    exp_q.delete();
    for (int b = N; b >= 0; b--) exp_q.push_back(data[b]);
    model_sr = data;
    sent = 0;
    stalled = 0;
    cycles = 0;
    @(negedge clk);
    in_valid = junk;
    in_data  = ~data;
    while (exp_q.size() > 0) begin
      checks++; if (ser_valid !== 1'b1) begin errors++; $display("FAIL ser_valid bit%0d: got %b expected 1", sent, ser_valid); end
      checks++; if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL busy_ready bit%0d: got busy=%b in_ready=%b expected 1/0", sent, busy, in_ready); end
      checks++; if (ser_out !== exp_q[0]) begin errors++; $display("FAIL ser_out bit%0d of %h: got %b expected %b", sent, data, ser_out, exp_q[0]); end
      checks++; if (ser_last !== (exp_q.size() == 1)) begin errors++; $display("FAIL ser_last bit%0d: got %b expected %b", sent, ser_last, exp_q.size() == 1); end
      checks++; if (shreg !== model_sr) begin errors++; $display("FAIL shreg bit%0d: got %h expected %h", sent, shreg, model_sr); end
      if (abort_at == sent) begin
        rst = 1'b1;
        ser_ready = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        exp_q.delete();
        checks++; if (busy !== 1'b0 || ser_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL abort_state: got busy=%b ser_valid=%b in_ready=%b expected 0/0/1", busy, ser_valid, in_ready); end
        checks++; if (shreg !== '0 || ser_out !== 1'b0 || ser_last !== 1'b0) begin errors++; $display("FAIL abort_data: got shreg=%h ser_out=%b ser_last=%b expected 0/0/0", shreg, ser_out, ser_last); end
        repeat (3) begin
          @(negedge clk);
          checks++; if (ser_valid !== 1'b0) begin errors++; $display("FAIL abort_quiet: got ser_valid=%b expected 0", ser_valid); end
        end
        return;
      end
      if (rand_ready) rdy = 1'($urandom_range(0, 1));
      else rdy = !(sent == stall_at && stalled < stall_len);
      ser_ready = rdy;
      if (junk) in_data = W'($urandom);
      @(negedge clk);
      if (rdy) begin
        void'(exp_q.pop_front());
        model_sr = model_sr << 1;
        sent++;
      end else begin
        stalled++;
      end
      cycles++;
      if (cycles > 400) begin
        errors++;
        $display("FAIL word_timeout: got %0d bits expected %0d", sent, W);
        exp_q.delete();
      end
    end
    checks++; if (sent !== W) begin errors++; $display("FAIL bit_count: got %0d expected %0d", sent, W); end
    checks++; if (busy !== 1'b0 || ser_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL end_state: got busy=%b ser_valid=%b in_ready=%b expected 0/0/1", busy, ser_valid, in_ready); end
    checks++; if (shreg !== '0 || ser_out !== 1'b0 || ser_last !== 1'b0) begin errors++; $display("FAIL end_data: got shreg=%h ser_out=%b ser_last=%b expected 0/0/0", shreg, ser_out, ser_last); end
    in_valid = 1'b0;
  endtask

  // Reset held with an accept offered: nothing loads, outputs at reset values.
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b1;
    ser_ready = 1'b0;
    repeat (3) begin
      in_data = W'($urandom_range(1, 255));
      @(negedge clk);
      checks++; if (busy !== 1'b0 || ser_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL reset_ctrl: got busy=%b ser_valid=%b in_ready=%b expected 0/0/1", busy, ser_valid, in_ready); end
      checks++; if (shreg !== '0 || ser_out !== 1'b0 || ser_last !== 1'b0) begin errors++; $display("FAIL reset_data: got shreg=%h ser_out=%b ser_last=%b expected 0/0/0", shreg, ser_out, ser_last); end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || shreg !== '0) begin errors++; $display("FAIL post_reset: got busy=%b shreg=%h expected 0/00", busy, shreg); end
  endtask

  task automatic test_basic();
    send_word(8'b0001_0111, -1, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_backpressure();
    // Stall while the 2nd bit (a 0) is presented.
    send_word(8'hA5, 1, 3, 1'b0, 1'b0, -1);
  endtask

  task automatic test_busy_ignore();
    send_word(8'hFF, -1, 0, 1'b0, 1'b1, -1);
  endtask

  task automatic test_back_to_back();
    send_word(8'hFF, -1, 0, 1'b0, 1'b1, -1);
    send_word(8'h01, -1, 0, 1'b0, 1'b1, -1);
  endtask

  task automatic test_reset_mid_word();
    send_word(8'h3C, -1, 0, 1'b0, 1'b0, 4);
    send_word(8'h81, -1, 0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 24; k++) begin
      send_word(W'($urandom), -1, 0, 1'b1, 1'($urandom_range(0, 1)), -1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_data = '0;
    in_valid = 1'b0;
    ser_ready = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_busy_ignore();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_reset_mid_word();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/lsl_serializer.md
LSL_SERIALIZER -- requirements
Module: lsl_serializer

Interface
REQ-001 SHALL have parameter N, default 7; data width is N+1 bits, index N is the MSB.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-004 SHALL have port in_data, input, N+1 bits: parallel word to serialize.
REQ-005 SHALL have port in_valid, input, 1 bit: in_data is valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block can accept a word.
REQ-007 SHALL have port ser_out, output, 1 bit: current serial bit, MSB first.
REQ-008 SHALL have port ser_valid, output, 1 bit: ser_out is valid.
REQ-009 SHALL have port ser_ready, input, 1 bit: downstream consumes ser_out.
REQ-010 SHALL have port ser_last, output, 1 bit: ser_out is the final (LSB) bit of the word.
REQ-011 SHALL have port shreg, output, N+1 bits: live shift-register contents.
REQ-012 SHALL have port busy, output, 1 bit: high while a word is in flight.

Function
REQ-013 SHALL implement the FSM states IDLE and SHIFT.
REQ-014 IDLE SHALL drive in_ready=1, ser_valid=0 and busy=0.
REQ-015 SHIFT SHALL drive in_ready=0, ser_valid=1 and busy=1.
REQ-016 Accept: in IDLE with in_valid=1 at a clock edge, SHALL load shreg<=in_data, set cnt<=0 and move to SHIFT.
REQ-017 The first bit SHALL be valid on the cycle after the accept (load-to-first-bit latency 1 cycle).
REQ-018 ser_out SHALL equal shreg[N] combinationally, and only while in SHIFT; in IDLE ser_out SHALL be 0.
REQ-019 Transfer SHALL occur on a cycle where ser_valid=1 and ser_ready=1.
REQ-020 On a transfer: shreg<={shreg[N-1:0],1'b0} (logical left shift, zero fill) and cnt<=cnt+1.
REQ-021 With ser_ready=0, shreg, cnt and ser_out SHALL hold unchanged (stall, any length).
REQ-022 ser_last SHALL be 1 iff state is SHIFT and cnt==N.
REQ-023 A transfer with ser_last=1 SHALL return the FSM to IDLE; shreg is then all zeros.
REQ-024 A word SHALL therefore produce exactly N+1 transfers.
REQ-025 The minimum spacing between words SHALL be one IDLE cycle (no overlap of accept and last transfer).
REQ-026 in_valid while in SHIFT SHALL be ignored; in_data SHALL NOT be sampled.
REQ-027 cnt SHALL be ceil(log2(N+1)) bits wide and SHALL never exceed N (no wrap).

Reset
REQ-028 rst=1 at a clock edge SHALL force state=IDLE, shreg=0 and cnt=0, regardless of state or handshakes.
REQ-029 Reset outputs SHALL be: in_ready=1, ser_valid=0, ser_out=0, ser_last=0, busy=0, shreg=0.
REQ-030 Reset mid-word SHALL discard the remaining bits; no further ser_valid until a new accept.
REQ-031 rst has priority over an accept presented in the same cycle.

Structure
REQ-032 Shared package lsl_pkg SHALL hold the state enum typedef (IDLE, SHIFT) and constant DEFAULT_N=7.
REQ-033 The bit counter SHALL be a sub-module named bit_counter, with ports clk, rst, clr, en and count, parameterised on width.
REQ-034 The shift register, FSM and output logic SHALL reside in lsl_serializer.

Verification
REQ-035 Basic word: N=7, in_data=8'b00010111 accepted, ser_ready=1 throughout -> ser_out 0,0,0,1,0,1,1,1 on 8 consecutive cycles starting 1 cycle after accept; ser_last only on the 8th; then IDLE with shreg=0.
REQ-036 Backpressure: word 8'hA5, ser_ready low for 3 cycles after the 2nd bit -> ser_out holds 0 and shreg holds during the stall; full sequence is 1,0,1,0,0,1,0,1 with no lost or duplicated bits.
REQ-037 Busy ignore: word 8'hFF accepted, then in_valid=1 with in_data=8'h00 during SHIFT -> all 8 bits are 1; 8'h00 is not loaded.
REQ-038 Back-to-back: 8'hFF then 8'h01 with in_valid held high -> the second accept occurs exactly one IDLE cycle after the first ser_last; output is 8 ones, then 0000_0001.
REQ-039 Reset mid-word: rst pulsed after the 4th bit of 8'h3C -> next cycle shows IDLE, ser_valid=0, shreg=0; a fresh word 8'h81 then serializes as 1,0,0,0,0,0,0,1.
REQ-040 Simultaneous events: rst=1 together with in_valid=1 -> no load occurs and busy stays 0.
